// File: rtl/gyro_frame_rx.sv
// gyro_frame_rx: UART 8N1 byte receiver with 8-byte gyro frame decoder (x, y, z words + 0x55 0x55 trailer)
module gyro_frame_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        GCLK,
    input  logic        RST,
    input  logic        rxIN,
    output logic [7:0]  byte_data_out,
    output logic        byte_valid_out,
    output logic        framing_err_out,
    output logic [15:0] x_axis_out,
    output logic [15:0] y_axis_out,
    output logic [15:0] z_axis_out,
    output logic        frame_valid_out
);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        bvalid_q, bvalid_d;
    logic        ferr_q, ferr_d;
    logic [63:0] hist_q, hist_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic        fvalid_q, fvalid_d;
    logic        rxs;
    logic [63:0] hist_sh;
    logic        match;

    assign rxs     = sync_q[1];
    assign hist_sh = {byte_q, hist_q[63:8]};
    // the completing byte becomes h[7] and the current h[7] becomes h[6]
    assign match   = (cnt_q >= 4'd7) && (hist_q[63:56] == 8'h55) && (byte_q == 8'h55);

    // bit-level receive FSM: mid-bit sampling timed from the start-bit falling edge
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 16'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        bvalid_d = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rxs) state_d = START;
            end
            START: if (timer_q == HALF_M1) begin
                timer_d = '0;
                bit_d   = '0;
                state_d = rxs ? IDLE : DATA;
            end
            DATA: if (timer_q == FULL_M1) begin
                timer_d = '0;
                shift_d = {rxs, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: if (timer_q == FULL_M1) begin
                timer_d  = '0;
                byte_d   = rxs ? shift_q : byte_q;
                bvalid_d = rxs;
                ferr_d   = !rxs;
                state_d  = rxs ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                timer_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // frame layer: slide history on each byte, match on a full window ending in 0x55 0x55
    always_comb begin
        hist_d   = hist_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        fvalid_d = 1'b0;
        if (bvalid_q) begin
            hist_d   = hist_sh;
            cnt_d    = match ? 4'd0 : (cnt_q == 4'd8 ? 4'd8 : cnt_q + 4'd1);
            fvalid_d = match;
            x_d      = match ? hist_sh[15:0]  : x_q;
            y_d      = match ? hist_sh[31:16] : y_q;
            z_d      = match ? hist_sh[47:32] : z_q;
        end else if (ferr_q) begin
            cnt_d = '0;
        end
    end

    // state registers, synchronizer held high in reset so no false start follows release
    always_ff @(posedge GCLK or posedge RST) begin
        if (RST) begin
            sync_q   <= 2'b11;
            state_q  <= IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            bvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            hist_q   <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            fvalid_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], rxIN};
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            bvalid_q <= bvalid_d;
            ferr_q   <= ferr_d;
            hist_q   <= hist_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            fvalid_q <= fvalid_d;
        end
    end

    assign byte_data_out   = byte_q;
    assign byte_valid_out  = bvalid_q;
    assign framing_err_out = ferr_q;
    assign x_axis_out      = x_q;
    assign y_axis_out      = y_q;
    assign z_axis_out      = z_q;
    assign frame_valid_out = fvalid_q;
endmodule

// File: doc/gyro_frame_rx.md
GYRO_FRAME_RX -- requirements
Module: gyro_frame_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 868, GCLK cycles per UART bit (100 MHz / 115200); legal range 8..65535.
REQ-002 Port: GCLK  input  1  system clock; all state on rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous, active-high.
REQ-004 Port: rxIN  input  1  UART serial line, idle high, 8N1, LSB first, asynchronous to GCLK.
REQ-005 Port: byte_data_out  output  8  last correctly received byte.
REQ-006 Port: byte_valid_out  output  1  one-cycle pulse when byte_data_out updates.
REQ-007 Port: framing_err_out  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 Port: x_axis_out  output  16  X word from the last valid frame.
REQ-009 Port: y_axis_out  output  16  Y word from the last valid frame.
REQ-010 Port: z_axis_out  output  16  Z word from the last valid frame.
REQ-011 Port: frame_valid_out  output  1  one-cycle pulse when the axis outputs update.

Function
REQ-012 rxIN passes through a 2-flop synchronizer before any use; the synchronized value is called rxs below.
REQ-013 The bit FSM has the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 IDLE: on rxs=0, enter START and clear the bit timer.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division), sample rxs; if rxs=0, enter DATA and clear the timer; if rxs=1, treat it as a glitch and return to IDLE with no output.
REQ-016 DATA: sample rxs every CLKS_PER_BIT cycles into bit[n], n=0..7, LSB first; after bit 7, enter STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, sample rxs.
- rxs=1: on the next cycle load byte_data_out, pulse byte_valid_out, and go to IDLE.
- rxs=0: pulse framing_err_out, discard the byte, and go to WAIT_IDLE.
REQ-018 WAIT_IDLE: stay until rxs=1, then go to IDLE; no start bit is detected while in WAIT_IDLE.
REQ-019 The frame format is 8 bytes in this order: x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8], 0x55, 0x55.
REQ-020 On each byte_valid_out, the byte shifts into an 8-byte history, with the newest byte at position 7.
- The same event increments a byte counter that saturates at 8.
REQ-021 Frame match condition: counter reaches 8 and history[6]=0x55 and history[7]=0x55.
REQ-022 On a frame match, in the cycle after the completing byte_valid_out:
- load x_axis_out={h[1],h[0]}, y_axis_out={h[3],h[2]} and z_axis_out={h[5],h[4]};
- pulse frame_valid_out;
- clear the counter to 0.
REQ-023 Without a frame match, the axis outputs hold their values; a mismatched window only slides the history by one byte, which provides resynchronization on an arbitrary start offset.
REQ-024 Because the counter clears on a match, 0x55 data bytes inside the next frame cannot cause an early match.
REQ-025 A framing error clears the byte counter; the history is not cleared.
REQ-026 byte_valid_out, framing_err_out and frame_valid_out never assert in the same cycle.
REQ-027 End-to-end latency is 1 cycle from the stop-bit sample to byte_valid_out, and 2 cycles to frame_valid_out.

Reset
REQ-028 While RST=1, the following are held at 0:
- all outputs;
- the history and the byte counter;
- the bit timer.
REQ-029 While RST=1, the FSM is held in IDLE and both synchronizer flops are held at 1.
REQ-030 RST asserted mid-byte or mid-frame abandons the partial byte or frame; after release, reception restarts at the next falling edge of rxs.

Verification (CLKS_PER_BIT=16)
REQ-031 Single byte 0xA5 with a valid stop bit -> byte_data_out=0xA5, exactly one byte_valid_out pulse, and no framing_err_out pulse.
REQ-032 Frame 34 12 78 56 BC 9A 55 55 -> x=0x1234, y=0x5678, z=0x9ABC, and one frame_valid_out pulse 1 cycle after the 8th byte_valid_out.
REQ-033 Three junk bytes 00 55 55, then a full frame with x=0x0001, y=0x0002, z=0x0003 -> no frame_valid_out on the junk bytes, and exactly one frame_valid_out with x=0x0001, y=0x0002, z=0x0003 after the full frame.
REQ-034 Byte 0x3C with stop bit 0 and rxIN held low for 40 cycles, then byte 0x11 -> one framing_err_out pulse, no byte_valid_out for 0x3C, then byte_data_out=0x11.
REQ-035 A 4-cycle low glitch on idle rxIN -> no outputs; then RST pulsed during bit 3 of a byte -> all outputs 0, and the next full frame decodes correctly.
